pe_mac_q: RTL and testbench

Parametrised systolic processing element for the YOLO-v3 convolution array: multiplies streaming signed operands, accumulates a dot product over a tile framed by valid/last, requantises the sum (round, shift, saturate) and drains the result down a per-column output chain. Operands and framing pass to the neighbouring PEs with one cycle of delay. It is the accumulator-with-handshake successor of the plain 16-bit MAC PE, instantiated in an R×C grid by the array top.

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_requant.sv | 43 ++++
 rtl/pe_mac_q.sv | 151 +++++++++++++++
 tb/tb_pe_mac_q.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the systolic MAC processing element.
// The array top imports the same defaults.
package pe_pkg;

    localparam int PE_DATA_W = 16;
    localparam int PE_ACC_W  = 40;
    localparam int PE_FRAC_W = 8;
    localparam int PE_OUT_W  = 16;

    typedef enum logic {
        PE_IDLE = 1'b0,
        PE_ACC  = 1'b1
    } pe_state_e;

endpackage

// File: rtl/pe_requant.sv
// Combinational requantiser: round-half-up, arithmetic shift right by FRAC_W,
// then saturate to a signed OUT_W result. The bias/output stage reuses it.
module pe_requant #(
    parameter int ACC_W  = 40,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic [ACC_W-1:0] sum_in,
    output logic [OUT_W-1:0] q_out
);

    // One guard bit so the rounding offset can never wrap the sum.
    localparam logic signed [ACC_W:0] Q_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] Q_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_ext;
    logic signed [ACC_W:0] sum_rnd;
    logic signed [ACC_W:0] sum_shf;

    assign sum_ext = $signed({sum_in[ACC_W-1], sum_in});

    generate
        if (FRAC_W > 0) begin : g_rnd
            localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_W-1);
            assign sum_rnd = sum_ext + HALF;
        end else begin : g_no_rnd
            assign sum_rnd = sum_ext;
        end
    endgenerate

    assign sum_shf = sum_rnd >>> FRAC_W;

    always_comb begin
        if (sum_shf > Q_MAX) begin
            q_out = Q_MAX[OUT_W-1:0];
        end else if (sum_shf < Q_MIN) begin
            q_out = Q_MIN[OUT_W-1:0];
        end else begin
            q_out = sum_shf[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pe_mac_q.sv
// Systolic MAC processing element: accumulates a valid/last framed dot product,
// requantises it and drains the result down the column chain behind upstream traffic.
module pe_mac_q
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W,
    parameter int FRAC_W = PE_FRAC_W,
    parameter int OUT_W  = PE_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              valid_in,
    input  logic              last_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              last_out,
    input  logic [OUT_W-1:0]  c_in,
    input  logic              c_valid_in,
    output logic [OUT_W-1:0]  c_out,
    output logic              c_valid_out,
    output logic              err
);

    pe_state_e state_q, state_d;

    logic [DATA_W-1:0] a_q, b_q;
    logic              valid_q, last_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [OUT_W-1:0]  c_q, c_d;
    logic              c_valid_q, c_valid_d;
    logic              err_q, err_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]           fin_sum;
    logic [OUT_W-1:0]           fin_q;
    logic                       fin;
    logic                       drain;

    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = ACC_W'(prod);
    assign fin_sum  = (state_q == PE_ACC) ? acc_q + prod_ext : prod_ext;

    pe_requant #(
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_requant (
        .sum_in (fin_sum),
        .q_out  (fin_q)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        c_d          = c_q;
        c_valid_d    = 1'b0;
        err_d        = err_q;
        fin          = 1'b0;

        case (state_q)
            PE_IDLE: begin
                if (valid_in) begin
                    if (last_in) begin
                        fin = 1'b1;
                    end else begin
                        acc_d   = prod_ext;
                        state_d = PE_ACC;
                    end
                end
            end
            PE_ACC: begin
                if (valid_in) begin
                    if (last_in) begin
                        fin     = 1'b1;
                        acc_d   = '0;
                        state_d = PE_IDLE;
                    end else begin
                        acc_d = acc_q + prod_ext;
                    end
                end
            end
            default: state_d = PE_IDLE;
        endcase

        // Upstream results always win the column; the local one waits.
        drain = pend_valid_q && !c_valid_in;
        if (c_valid_in) begin
            c_d       = c_in;
            c_valid_d = 1'b1;
        end else if (pend_valid_q) begin
            c_d       = pend_q;
            c_valid_d = 1'b1;
        end

        if (fin) begin
            pend_d       = fin_q;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !drain) begin
                err_d = 1'b1;
            end
        end else if (drain) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PE_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            acc_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            c_q          <= '0;
            c_valid_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_in;
            b_q          <= b_in;
            valid_q      <= valid_in;
            last_q       <= last_in;
            acc_q        <= acc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            c_q          <= c_d;
            c_valid_q    <= c_valid_d;
            err_q        <= err_d;
        end
    end

    assign a_out       = a_q;
    assign b_out       = b_q;
    assign valid_out   = valid_q;
    assign last_out    = last_q;
    assign c_out       = c_q;
    assign c_valid_out = c_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pe_mac_q.sv
// Bench for pe_mac_q: directed literal cases plus randomized traffic checked
// every cycle against a tile-level arithmetic model.
module tb_pe_mac_q;
    import pe_pkg::*;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int FW = 8;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [DW-1:0] a_in = '0, b_in = '0;
    logic valid_in = 1'b0, last_in = 1'b0;
    logic signed [OW-1:0] c_in = '0;
    logic c_valid_in = 1'b0;

    logic [DW-1:0] a_out, b_out;
    logic valid_out, last_out;
    logic [OW-1:0] c_out;
    logic c_valid_out, err;

    pe_mac_q #(.DATA_W(DW), .ACC_W(AW), .FRAC_W(FW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .b_in(b_in), .valid_in(valid_in), .last_in(last_in),
        .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .last_out(last_out),
        .c_in(c_in), .c_valid_in(c_valid_in),
        .c_out(c_out), .c_valid_out(c_valid_out), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact tile sum, round-half-up via floor shift, clamp.
    function automatic longint rq(input longint s);
        longint t;
        t = (s + (64'sd1 <<< (FW-1))) >>> FW;
        if (t > (64'sd1 <<< (OW-1)) - 1) t = (64'sd1 <<< (OW-1)) - 1;
        if (t < -(64'sd1 <<< (OW-1)))    t = -(64'sd1 <<< (OW-1));
        return t;
    endfunction

    longint m_sum = 0, m_pend = 0, m_c = 0, m_a = 0, m_b = 0;
    bit m_in_tile = 0, m_pend_v = 0, m_cv = 0, m_err = 0, m_v = 0, m_l = 0;

    always @(posedge clk) begin
        longint v, fv;
        bit fin, drained;
        if (rst) begin
            m_sum = 0; m_pend = 0; m_c = 0; m_a = 0; m_b = 0;
            m_in_tile = 0; m_pend_v = 0; m_cv = 0; m_err = 0; m_v = 0; m_l = 0;
        end else begin
            m_a = longint'(a_in); m_b = longint'(b_in); m_v = valid_in; m_l = last_in;
            fin = 0; fv = 0;
            if (valid_in) begin
                v = (m_in_tile ? m_sum : 0) + longint'(a_in) * longint'(b_in);
                if (last_in) begin
                    fin = 1; fv = rq(v); m_in_tile = 0; m_sum = 0;
                end else begin
                    m_sum = v; m_in_tile = 1;
                end
            end
            drained = 0;
            if (c_valid_in) begin
                m_c = longint'(c_in); m_cv = 1;
            end else if (m_pend_v) begin
                m_c = m_pend; m_cv = 1; drained = 1;
            end else begin
                m_cv = 0;
            end
            if (fin) begin
                if (m_pend_v && !drained) m_err = 1;
                m_pend = fv; m_pend_v = 1;
            end else if (drained) begin
                m_pend_v = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("a_out",       longint'($signed(a_out)), m_a);
        check("b_out",       longint'($signed(b_out)), m_b);
        check("valid_out",   longint'(valid_out), longint'(m_v));
        check("last_out",    longint'(last_out), longint'(m_l));
        check("c_valid_out", longint'(c_valid_out), longint'(m_cv));
        check("c_out",       longint'($signed(c_out)), m_c);
        check("err",         longint'(err), longint'(m_err));
    end

    task automatic drive(input int a, input int b, input bit v, input bit l,
                         input bit cv, input int ci);
        @(negedge clk);
        a_in = DW'(a); b_in = DW'(b); valid_in = v; last_in = l;
        c_valid_in = cv; c_in = OW'(ci);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_result(input string name, input longint exp, input int budget);
        int n = 0;
        while (!c_valid_out && n < budget) begin
            idle();
            cyc();
            n++;
        end
        if (!c_valid_out) check({name, "_timeout"}, 0, 1);
        else check(name, longint'($signed(c_out)), exp);
    endtask

    int rt_a [8] = '{1, 1, -1, -1, 32767, -32768, 256, -256};
    int rt_b [8] = '{128, 127, 128, 129, 32767, 32767, 512, 255};
    longint rt_e [8] = '{1, 0, 0, -1, 32767, -32768, 512, -255};

    initial begin
        rst = 1'b1;
        repeat (3) cyc();
        check("rst_c_valid_out", longint'(c_valid_out), 0);
        check("rst_err", longint'(err), 0);
        check("rst_c_out", longint'(c_out), 0);
        rst = 1'b0;

        // single beat: pass-through after 1 cycle, result exactly 2 cycles after beat
        drive(256, 512, 1, 1, 0, 0); cyc();
        check("single_a_out", longint'($signed(a_out)), 256);
        check("single_cv_early", longint'(c_valid_out), 0);
        idle(); cyc();
        check("single_cv", longint'(c_valid_out), 1);
        check("single_c_out", longint'($signed(c_out)), 512);
        idle(); cyc();
        check("single_cv_drop", longint'(c_valid_out), 0);

        // tile with a bubble, then back-to-back single beat tile
        drive(256, 256, 1, 0, 0, 0); cyc();
        drive(256, -128, 1, 0, 0, 0); cyc();
        idle(); cyc();
        drive(256, 384, 1, 0, 0, 0); cyc();
        drive(256, 0, 1, 1, 0, 0); cyc();
        drive(256, 256, 1, 1, 0, 0); cyc();
        check("tile_c_out", longint'($signed(c_out)), 512);
        idle(); cyc();
        check("tile2_c_out", longint'($signed(c_out)), 256);
        idle(); cyc();

        foreach (rt_a[i]) begin
            drive(rt_a[i], rt_b[i], 1, 1, 0, 0); cyc();
            expect_result($sformatf("rq_%0d", i), rt_e[i], 4);
            idle(); cyc();
        end

        // drain priority: upstream wins, local result one cycle later
        drive(256, 256, 1, 1, 0, 0); cyc();
        drive(0, 0, 0, 0, 1, 16'h1111); cyc();
        check("prio_upstream", longint'(c_out), 16'h1111);
        idle(); cyc();
        check("prio_local", longint'($signed(c_out)), 256);
        check("prio_err", longint'(err), 0);
        idle(); cyc();
        drive(256, 256, 1, 1, 1, 16'h2222); cyc();
        drive(256, 512, 1, 1, 1, 16'h2222); cyc();
        check("ovw_err", longint'(err), 1);
        check("ovw_upstream", longint'(c_out), 16'h2222);
        idle(); cyc();
        check("ovw_newer", longint'($signed(c_out)), 512);
        idle(); cyc();
        check("ovw_err_sticky", longint'(err), 1);

        // reset mid-tile discards the partial sum
        drive(256, 256, 1, 0, 0, 0); cyc();
        drive(256, 256, 1, 0, 0, 0); cyc();
        idle(); rst = 1'b1; cyc();
        check("mid_rst_a_out", longint'(a_out), 0);
        check("mid_rst_c_out", longint'(c_out), 0);
        check("mid_rst_err", longint'(err), 0);
        rst = 1'b0;
        drive(256, 256, 1, 1, 0, 0); cyc();
        expect_result("after_rst", 256, 4);

        // randomized traffic, checked each cycle by the model
        for (int n = 0; n < 4000; n++) begin
            int a, b;
            if ($urandom_range(3) == 0) begin
                a = int'($signed(16'($urandom))); b = int'($signed(16'($urandom)));
            end else begin
                a = $urandom_range(2000) - 1000; b = $urandom_range(2000) - 1000;
            end
            drive(a, b, $urandom_range(3) != 0, $urandom_range(3) == 0,
                  $urandom_range(4) == 0, int'($urandom_range(65535)));
            rst = ($urandom_range(299) == 0);
            cyc();
        end
        rst = 1'b0;
        idle(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
